wb_labs_search: RTL

Wishbone-mapped low-autocorrelation binary sequence (LABS) search engine for the Caravel user area. Software programs an inclusive candidate range. `PARALLEL_UNITS` energy evaluators then sweep it in batches and report the minimum-energy sequence, its energy and the tie count. An optional threshold mode stops at the first sequence at or below a target energy, with an interrupt on completion.

---
 rtl/labs_search_pkg.sv | 26 ++
 rtl/labs_energy_unit.sv | 54 +++++
 rtl/wb_labs_search.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/labs_search_pkg.sv
// labs_search_pkg: register map, status bits, FSM encoding and energy bound for the LABS search engine
package labs_search_pkg;
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_START    = 3'd2;
  localparam logic [2:0] REG_END      = 3'd3;
  localparam logic [2:0] REG_THRESH   = 3'd4;
  localparam logic [2:0] REG_BEST_E   = 3'd5;
  localparam logic [2:0] REG_BEST_SEQ = 3'd6;
  localparam logic [2:0] REG_TIE      = 3'd7;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_MODE   = 3;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_FOUND  = 2;
  localparam int STAT_EMPTY  = 3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_REDUCE, S_DONE} state_t;
  function automatic int unsigned max_energy(input int unsigned n);
    int unsigned e;
    e = 0;
    for (int unsigned k = 1; k < n; k++) e += (n - k) * (n - k);
    return e;
  endfunction
endpackage

// File: rtl/labs_energy_unit.sv
// labs_energy_unit: accumulates the LABS energy of one sequence, one autocorrelation lag per cycle
module labs_energy_unit
  import labs_search_pkg::*;
#(
  parameter int SEQ_WIDTH = 16,
  parameter int E_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [SEQ_WIDTH-1:0] seq_i,
  input  logic                 mask_i,
  output logic [E_WIDTH-1:0]   energy_o,
  output logic                 valid_o
);
  localparam int KW = $clog2(SEQ_WIDTH);
  logic [SEQ_WIDTH-1:0] seq_q, x;
  logic [KW-1:0]        k_q;
  logic [E_WIDTH-1:0]   acc_q, term;
  logic                 run_q, valid_q;
  int                   pop, c;
  // C_k from the mismatch count between s and s shifted by k over the N-k overlapping bits
  always_comb begin
    x = seq_q ^ (seq_q >> k_q);
    pop = 0;
    for (int i = 0; i < SEQ_WIDTH; i++) pop += (i < SEQ_WIDTH - int'(k_q)) ? int'(x[i]) : 0;
    c = SEQ_WIDTH - int'(k_q) - 2 * pop;
    term = E_WIDTH'(c * c);
  end
  // lag sweep k = 1..N-1; masked lanes never run and never report valid
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      seq_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      seq_q   <= seq_i;
      k_q     <= KW'(1);
      acc_q   <= '0;
      run_q   <= ~mask_i;
      valid_q <= 1'b0;
    end else if (run_q) begin
      acc_q <= acc_q + term;
      k_q   <= k_q + 1'b1;
      if (k_q == KW'(SEQ_WIDTH - 1)) begin
        run_q   <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  assign energy_o = acc_q;
  assign valid_o  = valid_q;
endmodule

// File: rtl/wb_labs_search.sv
// wb_labs_search: Wishbone-mapped batched LABS minimum/threshold search engine
module wb_labs_search
  import labs_search_pkg::*;
#(
  parameter int          SEQ_WIDTH      = 16,
  parameter int          E_WIDTH        = 16,
  parameter int          PARALLEL_UNITS = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);
  localparam int CW = SEQ_WIDTH + 1;
  localparam int KW = $clog2(SEQ_WIDTH);
  state_t               state_q, state_d;
  logic                 ack_q, start_q, irq_en_q, mode_q, done_q, found_q, empty_q;
  logic [31:0]          dat_q, rdata, tie_q, tie_d;
  logic [SEQ_WIDTH-1:0] start_seq_q, end_seq_q, best_seq_q, best_seq_d;
  logic [E_WIDTH-1:0]   thresh_q, best_e_q, best_e_d;
  logic [CW-1:0]        cand_q;
  logic [KW-1:0]        cnt_q;
  logic [SEQ_WIDTH-1:0] run_end_q;
  logic [E_WIDTH-1:0]   run_thr_q;
  logic                 run_mode_q, found_d, last_d;
  logic                 acc, hit, wr, wr_ctrl, abort_w, empty_w;
  logic [2:0]           off;
  logic [CW-1:0]        lane [PARALLEL_UNITS];
  logic [E_WIDTH-1:0]   u_energy [PARALLEL_UNITS];
  logic [PARALLEL_UNITS-1:0] u_valid;
  logic                 unused_ok;
  assign acc       = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit       = wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign off       = wbs_adr_i[4:2];
  assign wr        = acc & wbs_we_i & (&wbs_sel_i) & hit;
  assign wr_ctrl   = wr && off == REG_CTRL;
  assign abort_w   = wr_ctrl && wbs_dat_i[CTRL_ABORT];
  assign empty_w   = end_seq_q < start_seq_q;
  assign busy_o    = state_q != S_IDLE;
  assign irq_o     = done_q & irq_en_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i};
  for (genvar g = 0; g < PARALLEL_UNITS; g++) begin : g_lane
    assign lane[g] = cand_q + CW'(g);
    labs_energy_unit #(.SEQ_WIDTH(SEQ_WIDTH), .E_WIDTH(E_WIDTH)) u_unit (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .start_i  (state_q == S_LOAD),
      .seq_i    (lane[g][SEQ_WIDTH-1:0]),
      .mask_i   (lane[g] > {1'b0, run_end_q}),
      .energy_o (u_energy[g]),
      .valid_o  (u_valid[g])
    );
  end
  // register read mux; anything outside the 32-byte block reads as zero
  always_comb begin
    rdata = '0;
    if (hit)
      case (off)
        REG_CTRL:     rdata[3:0] = {mode_q, irq_en_q, 1'b0, start_q};
        REG_STATUS: begin
          rdata[STAT_BUSY]  = busy_o;
          rdata[STAT_DONE]  = done_q;
          rdata[STAT_FOUND] = found_q;
          rdata[STAT_EMPTY] = empty_q;
        end
        REG_START:    rdata = 32'(start_seq_q);
        REG_END:      rdata = 32'(end_seq_q);
        REG_THRESH:   rdata = 32'(thresh_q);
        REG_BEST_E:   rdata = 32'(best_e_q);
        REG_BEST_SEQ: rdata = 32'(best_seq_q);
        REG_TIE:      rdata = tie_q;
      endcase
  end
  // lane-ordered reduction: ascending lanes make the lowest sequence win ties
  always_comb begin
    best_e_d   = best_e_q;
    best_seq_d = best_seq_q;
    tie_d      = tie_q;
    found_d    = 1'b0;
    for (int j = 0; j < PARALLEL_UNITS; j++)
      if (u_valid[j] && !found_d) begin
        if (u_energy[j] < best_e_d) begin
          best_e_d   = u_energy[j];
          best_seq_d = lane[j][SEQ_WIDTH-1:0];
          tie_d      = 32'd1;
        end else if (u_energy[j] == best_e_d) tie_d = tie_d + 32'd1;
        if (run_mode_q && u_energy[j] <= run_thr_q) begin
          found_d    = 1'b1;
          best_e_d   = u_energy[j];
          best_seq_d = lane[j][SEQ_WIDTH-1:0];
        end
      end
    last_d = found_d || (cand_q + CW'(PARALLEL_UNITS) > {1'b0, run_end_q});
  end
  // search sequencing; an abort write overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_q) state_d = empty_w ? S_DONE : S_LOAD;
      S_LOAD:   state_d = S_EVAL;
      S_EVAL:   if (cnt_q == KW'(SEQ_WIDTH - 1)) state_d = S_REDUCE;
      S_REDUCE: state_d = last_d ? S_DONE : S_LOAD;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_w) state_d = S_IDLE;
  end
  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state_q <= S_IDLE;
    else state_q <= state_d;
  // bus handshake, register file and per-search bookkeeping
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      start_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      empty_q     <= 1'b0;
      start_seq_q <= '0;
      end_seq_q   <= '0;
      thresh_q    <= '0;
      best_e_q    <= '1;
      best_seq_q  <= '1;
      tie_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      run_end_q   <= '0;
      run_thr_q   <= '0;
      run_mode_q  <= 1'b0;
    end else begin
      ack_q   <= acc;
      dat_q   <= (acc && !wbs_we_i) ? rdata : '0;
      start_q <= wr_ctrl && wbs_dat_i[CTRL_START] && !wbs_dat_i[CTRL_ABORT] && state_q == S_IDLE;
      if (wr_ctrl) begin
        irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
        mode_q   <= wbs_dat_i[CTRL_MODE];
      end
      if (wr && off == REG_START) start_seq_q <= wbs_dat_i[SEQ_WIDTH-1:0];
      if (wr && off == REG_END) end_seq_q <= wbs_dat_i[SEQ_WIDTH-1:0];
      if (wr && off == REG_THRESH) thresh_q <= wbs_dat_i[E_WIDTH-1:0];
      if (wr && off == REG_STATUS && wbs_dat_i[STAT_DONE]) done_q <= 1'b0;
      if (state_q == S_IDLE && start_q) begin
        best_e_q   <= '1;
        tie_q      <= '0;
        found_q    <= 1'b0;
        done_q     <= 1'b0;
        empty_q    <= empty_w;
        cand_q     <= {1'b0, start_seq_q};
        run_end_q  <= end_seq_q;
        run_thr_q  <= thresh_q;
        run_mode_q <= mode_q;
      end
      if (state_q == S_LOAD) cnt_q <= KW'(1);
      if (state_q == S_EVAL) cnt_q <= cnt_q + 1'b1;
      if (state_q == S_REDUCE) begin
        best_e_q   <= best_e_d;
        best_seq_q <= best_seq_d;
        tie_q      <= tie_d;
        found_q    <= found_d;
        if (!last_d) cand_q <= cand_q + CW'(PARALLEL_UNITS);
      end
      if (state_q == S_DONE && !abort_w) done_q <= 1'b1;
    end
endmodule
